// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS MEM-stage load/store unit.
// Holds the opcode encodings, response error codes, the FSM state encoding
// and small opcode-classification helpers.
package mips_mem_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ERR_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_LB  = 6'h20;
    localparam logic [OPCODE_W-1:0] OP_LH  = 6'h21;
    localparam logic [OPCODE_W-1:0] OP_LW  = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_LBU = 6'h24;
    localparam logic [OPCODE_W-1:0] OP_LHU = 6'h25;
    localparam logic [OPCODE_W-1:0] OP_SB  = 6'h28;
    localparam logic [OPCODE_W-1:0] OP_SH  = 6'h29;
    localparam logic [OPCODE_W-1:0] OP_SW  = 6'h2B;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0] ERR_ALIGN   = 2'd1;
    localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'd2;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } mau_state_e;

    // True for the five load opcodes.
    function automatic logic op_is_load(input logic [OPCODE_W-1:0] op);
        logic r;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the three store opcodes.
    function automatic logic op_is_store(input logic [OPCODE_W-1:0] op);
        logic r;
        case (op)
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    // Halfword-sized accesses.
    function automatic logic op_is_half(input logic [OPCODE_W-1:0] op);
        logic r;
        case (op)
            OP_LH, OP_LHU, OP_SH: r = 1'b1;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    // Word-sized accesses.
    function automatic logic op_is_word(input logic [OPCODE_W-1:0] op);
        logic r;
        case (op)
            OP_LW, OP_SW: r = 1'b1;
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   opcode, addr_lo : access type and byte offset within the word
//   wdata           : raw store data (rt value)
//   rdata           : word read from memory
//   be_c            : byte enables (bit i covers bits [8i+7:8i])
//   wdata_c         : store data replicated onto the addressed lanes
//   load_c          : extracted and sign/zero-extended load data (0 for non-loads)
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [1:0]          addr_lo,
    input  logic [31:0]         wdata,
    input  logic [31:0]         rdata,
    output logic [3:0]          be_c,
    output logic [31:0]         wdata_c,
    output logic [31:0]         load_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection from the read word.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Byte enables, store replication and load extension.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        load_c  = '0;
        case (opcode)
            OP_SB: begin
                be_c    = 4'b0001 << addr_lo;
                wdata_c = {4{wdata[7:0]}};
            end
            OP_SH: begin
                be_c    = 4'b0011 << addr_lo;
                wdata_c = {2{wdata[15:0]}};
            end
            OP_LB:   load_c = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_c = {24'h000000, byte_sel};
            OP_LH:   load_c = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_c = {16'h0000, half_sel};
            OP_LW:   load_c = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM-stage load/store controller driving the data-memory port.
//   req_*   : one decoded load/store from the pipeline (valid/ready)
//   mem_*   : read/write strobes, word address, byte enables, data, ack
//   resp_*  : extended load data, echoed rt tag and error code (valid/ready)
// One transaction is in flight at most: IDLE -> (BUS) -> RESP -> IDLE.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OPCODE_W-1:0] req_opcode,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [4:0]          req_rt,
    output logic                mem_read,
    output logic                mem_write,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_be,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [31:0]         resp_data,
    output logic [4:0]          resp_rt,
    output logic [ERR_W-1:0]    resp_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    mau_state_e          state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [1:0]          lane_q, lane_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [4:0]          resp_rt_q, resp_rt_d;
    logic [ERR_W-1:0]    resp_err_q, resp_err_d;

    logic [ERR_W-1:0]    req_err_c;
    logic [OPCODE_W-1:0] al_op_c;
    logic [1:0]          al_lane_c;
    logic [3:0]          al_be_c;
    logic [31:0]         al_wdata_c;
    logic [31:0]         al_load_c;

    assign req_ready = (state_q == ST_IDLE);

    // In IDLE the aligner works on the incoming request; afterwards on the latched one.
    assign al_op_c   = (state_q == ST_IDLE) ? req_opcode     : op_q;
    assign al_lane_c = (state_q == ST_IDLE) ? req_addr[1:0]  : lane_q;

    lsu_lane_align u_align (
        .opcode  (al_op_c),
        .addr_lo (al_lane_c),
        .wdata   (req_wdata),
        .rdata   (mem_rdata),
        .be_c    (al_be_c),
        .wdata_c (al_wdata_c),
        .load_c  (al_load_c)
    );

    // Request screening: illegal opcode, then alignment, then range.
    always_comb begin
        req_err_c = ERR_NONE;
        if (!op_is_load(req_opcode) && !op_is_store(req_opcode)) begin
            req_err_c = ERR_ILLEGAL;
        end else if ((op_is_half(req_opcode) && req_addr[0]) ||
                     (op_is_word(req_opcode) && (req_addr[1:0] != 2'b00))) begin
            req_err_c = ERR_ALIGN;
        end else if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
            req_err_c = ERR_ILLEGAL;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_rt_d    = resp_rt_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d      = req_opcode;
                    lane_d    = req_addr[1:0];
                    resp_rt_d = req_rt;
                    cnt_d     = '0;
                    if (req_err_c != ERR_NONE) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = req_err_c;
                        resp_data_d  = '0;
                        state_d      = ST_RESP;
                    end else begin
                        mem_read_d  = op_is_load(req_opcode);
                        mem_write_d = op_is_store(req_opcode);
                        mem_addr_d  = {2'b00, req_addr[31:2]};
                        mem_be_d    = al_be_c;
                        mem_wdata_d = al_wdata_c;
                        state_d     = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (mem_ack) begin
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_NONE;
                    resp_data_d  = op_is_load(op_q) ? al_load_c : '0;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TIMEOUT;
                    resp_data_d  = '0;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            lane_q       <= '0;
            cnt_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rt_q    <= '0;
            resp_err_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rt_q    <= resp_rt_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_rt    = resp_rt_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected responses are queued when a
// request is driven and compared when the unit hands a response back.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_opcode = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rt = '0;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rt;
    logic [1:0]  resp_err;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rt;
        logic [1:0]  err;
    } resp_t;

    resp_t sb_q[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(256), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rt     (req_rt),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rt    (resp_rt),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Take one response and compare it against the oldest queued expectation.
    task automatic collect_resp(input string tag);
        resp_t exp_r;
        resp_ready = 1'b1;
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp_r = sb_q.pop_front();
            chk({tag, "_resp_data"}, resp_data, exp_r.data);
            chk({tag, "_resp_rt"}, 32'(resp_rt), 32'(exp_r.rt));
            chk({tag, "_resp_err"}, 32'(resp_err), 32'(exp_r.err));
        end
        tick();
        resp_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(req_ready), 32'd1);
    endtask

    // ack_cyc: BUS cycle (1-based) in which mem_ack is pulsed, 0 = never.
    task automatic run_txn(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rt, input int ack_cyc,
                           input logic [31:0] rdata, input int exp_strobes, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_data,
                           input logic [1:0] exp_err, input int hold);
        resp_t exp_r;
        int    n;
        int    strobes;
        logic  is_store;
        is_store = op[3];
        wait_ready(tag);
        req_valid  = 1'b1;
        req_opcode = op;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rt     = rt;
        exp_r = '{data: exp_data, rt: rt, err: exp_err};
        sb_q.push_back(exp_r);
        tick();
        req_valid = 1'b0;
        if (exp_err != ERR_NONE && exp_strobes == 0) begin
            chk({tag, "_err_latency"}, 32'(resp_valid), 32'd1);
            chk({tag, "_no_strobe"}, 32'({mem_read, mem_write}), 32'd0);
        end else begin
            chk({tag, "_no_early_resp"}, 32'(resp_valid), 32'd0);
            chk({tag, "_strobe"}, 32'({mem_read, mem_write}), is_store ? 32'd1 : 32'd2);
            chk({tag, "_mem_addr"}, mem_addr, {2'b00, addr[31:2]});
            chk({tag, "_mem_be"}, 32'(mem_be), 32'(exp_be));
            if (is_store) chk({tag, "_mem_wdata"}, mem_wdata, exp_wd);
            strobes = 0;
            n = 0;
            while (!resp_valid && n < 40) begin
                if (mem_read || mem_write) strobes++;
                n++;
                if (n == ack_cyc) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                tick();
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
            end
            chk({tag, "_strobe_cycles"}, 32'(strobes), 32'(exp_strobes));
            chk({tag, "_strobe_drop"}, 32'({mem_read, mem_write}), 32'd0);
        end
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "_hold_data"}, resp_data, exp_data);
            chk({tag, "_hold_busy"}, 32'(req_ready), 32'd0);
            tick();
        end
        collect_resp(tag);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Stores
        run_txn("sb", OP_SB, 32'h0000000D, 32'h000000FD, 5'd5, 2, 32'h0, 2, 4'b0010, 32'hFDFDFDFD, 32'h0, ERR_NONE, 0);
        run_txn("sh", OP_SH, 32'h0000001E, 32'hABCD1234, 5'd6, 1, 32'h0, 1, 4'b1100, 32'h12341234, 32'h0, ERR_NONE, 0);
        run_txn("sw", OP_SW, 32'h00000020, 32'hDEADBEEF, 5'd7, 3, 32'h0, 3, 4'b1111, 32'hDEADBEEF, 32'h0, ERR_NONE, 0);

        // Loads from word 7 = 0x80FF7F01 (lanes: 01, 7F, FF, 80)
        run_txn("lb_1e", OP_LB, 32'h0000001E, 32'h0, 5'd8, 1, 32'h80FF7F01, 1, 4'b1111, 32'h0, 32'hFFFFFFFF, ERR_NONE, 0);
        run_txn("lb_1f", OP_LB, 32'h0000001F, 32'h0, 5'd9, 1, 32'h80FF7F01, 1, 4'b1111, 32'h0, 32'hFFFFFF80, ERR_NONE, 0);
        run_txn("lbu_1f", OP_LBU, 32'h0000001F, 32'h0, 5'd10, 1, 32'h80FF7F01, 1, 4'b1111, 32'h0, 32'h00000080, ERR_NONE, 0);
        run_txn("lbu_1d", OP_LBU, 32'h0000001D, 32'h0, 5'd11, 2, 32'h80FF7F01, 2, 4'b1111, 32'h0, 32'h0000007F, ERR_NONE, 0);
        run_txn("lh_1e", OP_LH, 32'h0000001E, 32'h0, 5'd12, 1, 32'h80FF7F01, 1, 4'b1111, 32'h0, 32'hFFFF80FF, ERR_NONE, 0);
        run_txn("lhu_1e", OP_LHU, 32'h0000001E, 32'h0, 5'd13, 1, 32'h80FF7F01, 1, 4'b1111, 32'h0, 32'h000080FF, ERR_NONE, 0);
        run_txn("lh_1c", OP_LH, 32'h0000001C, 32'h0, 5'd14, 1, 32'h1234F00D, 1, 4'b1111, 32'h0, 32'hFFFFF00D, ERR_NONE, 0);
        run_txn("lw_1c", OP_LW, 32'h0000001C, 32'h0, 5'd15, 1, 32'h80FF7F01, 1, 4'b1111, 32'h0, 32'h80FF7F01, ERR_NONE, 0);
        run_txn("lw_top", OP_LW, 32'h000003FC, 32'h0, 5'd16, 1, 32'h0BADF00D, 1, 4'b1111, 32'h0, 32'h0BADF00D, ERR_NONE, 0);

        // Errors, including check ordering
        run_txn("sh_misal", OP_SH, 32'h00000005, 32'h1111, 5'd17, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, ERR_ALIGN, 0);
        run_txn("op_22", 6'h22, 32'h00000010, 32'h0, 5'd18, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, ERR_ILLEGAL, 0);
        run_txn("op_22_misal", 6'h22, 32'h00000003, 32'h0, 5'd19, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, ERR_ILLEGAL, 0);
        run_txn("lw_range", OP_LW, 32'h00000400, 32'h0, 5'd20, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, ERR_ILLEGAL, 0);
        run_txn("lw_misal_range", OP_LW, 32'h00000401, 32'h0, 5'd21, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, ERR_ALIGN, 0);

        // Timeout and ack on the last allowed cycle
        run_txn("lw_timeout", OP_LW, 32'h00000010, 32'h0, 5'd22, 0, 32'h0, 16, 4'b1111, 32'h0, 32'h0, ERR_TIMEOUT, 0);
        run_txn("lw_ack16", OP_LW, 32'h00000010, 32'h0, 5'd23, 16, 32'hCAFE0001, 16, 4'b1111, 32'h0, 32'hCAFE0001, ERR_NONE, 0);

        // Backpressure: response held for 5 cycles
        run_txn("lhu_bp", OP_LHU, 32'h00000022, 32'h0, 5'd24, 1, 32'h9ABC5678, 1, 4'b1111, 32'h0, 32'h00009ABC, ERR_NONE, 5);

        // Stray ack while idle has no effect
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_valid", 32'(resp_valid), 32'd0);
        chk("stray_ack_ready", 32'(req_ready), 32'd1);

        // Reset mid-BUS aborts the access
        wait_ready("rst_mid");
        req_valid  = 1'b1;
        req_opcode = OP_LW;
        req_addr   = 32'h00000040;
        req_rt     = 5'd25;
        tick();
        req_valid = 1'b0;
        chk("rst_mid_strobe", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_drop", 32'(mem_read), 32'd0);
        chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mid_idle_valid", 32'(resp_valid), 32'd0);
            chk("rst_mid_idle_ready", 32'(req_ready), 32'd1);
        end

        // Recovery after reset
        run_txn("lb_after_rst", OP_LB, 32'h00000041, 32'h0, 5'd26, 1, 32'h00007F00, 1, 4'b1111, 32'h0, 32'h0000007F, ERR_NONE, 0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
